// File: rtl/nco_pkg.sv
// -----------------------------------------------------------------------------
// nco_pkg
// Shared constants and types for the NCO phase generator: the phase width
// (fixed at 32 to match the CORDIC cosine stage), the config register map,
// the CTRL bit positions and the control FSM state enum.
// -----------------------------------------------------------------------------
package nco_pkg;

  localparam int PHASE_W = 32;

  // Config register map
  localparam logic [2:0] NCO_ADDR_FTW    = 3'd0;
  localparam logic [2:0] NCO_ADDR_OFFSET = 3'd1;
  localparam logic [2:0] NCO_ADDR_DIV    = 3'd2;
  localparam logic [2:0] NCO_ADDR_CTRL   = 3'd3;
  localparam logic [2:0] NCO_ADDR_STEP   = 3'd4;
  localparam logic [2:0] NCO_ADDR_LIMIT  = 3'd5;

  // CTRL bit positions; PCLR and OCLR act only on the cycle of the write
  localparam int NCO_CTRL_EN   = 0;
  localparam int NCO_CTRL_PCLR = 1;
  localparam int NCO_CTRL_OCLR = 2;

  typedef enum logic [1:0] {
    NCO_IDLE  = 2'd0,
    NCO_RUN   = 2'd1,
    NCO_DRAIN = 2'd2
  } nco_state_e;

endpackage

// File: rtl/nco_phase_gen_if.sv
// -----------------------------------------------------------------------------
// nco_phase_gen_if
// Bundles the config write bus and the angle valid/ready stream of the NCO.
//   cfg_we / cfg_addr / cfg_wdata : register writes from the UDM bus
//   angle / angle_valid           : sample stream to the cosine stage
//   angle_ready                   : backpressure from the cosine stage
//   running / overrun             : status
// modport master : the system side (bus master and sample consumer)
// modport slave  : the NCO itself
// -----------------------------------------------------------------------------
interface nco_phase_gen_if;
  import nco_pkg::*;

  logic                cfg_we;
  logic [2:0]          cfg_addr;
  logic [31:0]         cfg_wdata;
  logic [PHASE_W-1:0]  angle;
  logic                angle_valid;
  logic                angle_ready;
  logic                running;
  logic                overrun;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, angle_ready,
    input  angle, angle_valid, running, overrun
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, angle_ready,
    output angle, angle_valid, running, overrun
  );

endinterface

// File: rtl/nco_tick_div.sv
// -----------------------------------------------------------------------------
// nco_tick_div
// Sample-rate divider: a DIV_W down-counter producing one tick every
// i_div+1 enabled cycles.
//   clock, reset : system clock, synchronous active-high reset
//   i_enable     : count (only while the NCO is running)
//   i_reload     : load the counter from i_div; suppresses a tick that cycle
//   i_div        : divider value, sampled only at (re)load
//   o_tick       : one-cycle tick
// -----------------------------------------------------------------------------
module nco_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_reload,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  // A forced reload (start or phase clear) wins over a tick that would
  // otherwise fire in the same cycle.
  assign o_tick = i_enable && !i_reload && (r_cnt == '0);

  // Counter: explicit reload, otherwise count down and wrap back to i_div.
  // A new i_div therefore only takes effect at the next reload.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_reload) begin
      r_cnt <= i_div;
    end else if (i_enable) begin
      if (r_cnt == '0) r_cnt <= i_div;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/nco_phase_gen.sv
// -----------------------------------------------------------------------------
// nco_phase_gen
// Numerically controlled phase generator. A 32-bit phase accumulator advances
// by FTW on each divider tick; each sample (acc + OFFSET) is offered on a
// valid/ready stream to the cosine stage. All outputs are registered.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : config writes, angle stream, running/overrun status
// Build option: define NCO_SWEEP_EN for the linear frequency sweep
// (STEP/LIMIT registers, sawtooth chirp back to FTW_START).
// -----------------------------------------------------------------------------
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic      clock,
  input  logic      reset,
  nco_phase_gen_if.slave bus
);

  nco_state_e         r_state;
  nco_state_e         w_next_state;

  logic [PHASE_W-1:0] r_ftw;
  logic [PHASE_W-1:0] r_offset;
  logic [DIV_W-1:0]   r_div;
  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_angle;
  logic               r_valid;
  logic               r_running;
  logic               r_overrun;

  logic               w_ctrl_wr;
  logic               w_start;
  logic               w_phase_clr;
  logic               w_ovr_clr;
  logic               w_tick;
  logic               w_accept;
  logic               w_produce;
  logic               w_drop;
  logic               w_valid_next;

`ifdef NCO_SWEEP_EN
  logic [PHASE_W-1:0] r_ftw_start;
  logic [PHASE_W-1:0] r_step;
  logic [PHASE_W-1:0] r_limit;
  logic [PHASE_W-1:0] w_ftw_sum;
  logic [PHASE_W-1:0] w_ftw_swept;
  logic               w_step_pos;
  logic               w_step_neg;
`endif

  assign w_ctrl_wr   = bus.cfg_we && (bus.cfg_addr == NCO_ADDR_CTRL);
  assign w_start     = w_ctrl_wr && bus.cfg_wdata[NCO_CTRL_EN] && (r_state == NCO_IDLE);
  assign w_phase_clr = w_ctrl_wr && bus.cfg_wdata[NCO_CTRL_PCLR];
  assign w_ovr_clr   = w_ctrl_wr && bus.cfg_wdata[NCO_CTRL_OCLR];

  // The slot is free if empty or being drained this very cycle, which gives
  // one sample per clock at DIV=0 with ready held high.
  assign w_accept     = r_valid && bus.angle_ready;
  assign w_produce    = w_tick && (!r_valid || bus.angle_ready);
  assign w_drop       = w_tick && r_valid && !bus.angle_ready;
  assign w_valid_next = w_produce ? 1'b1 : (w_accept ? 1'b0 : r_valid);

  nco_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clock    (clock),
    .reset    (reset),
    .i_enable (r_state == NCO_RUN),
    .i_reload (w_start || w_phase_clr),
    .i_div    (r_div),
    .o_tick   (w_tick)
  );

`ifdef NCO_SWEEP_EN
  // Sweep step: STEP is signed, LIMIT compared unsigned against the new FTW.
  assign w_ftw_sum   = r_ftw + r_step;
  assign w_step_pos  = !r_step[PHASE_W-1] && (r_step != '0);
  assign w_step_neg  = r_step[PHASE_W-1];
  assign w_ftw_swept = ((w_step_pos && (w_ftw_sum > r_limit)) ||
                        (w_step_neg && (w_ftw_sum < r_limit))) ? r_ftw_start : w_ftw_sum;
`endif

  // Config registers. A tick in the same cycle still sees the old values;
  // a bus write to FTW wins over a sweep update in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ftw    <= '0;
      r_offset <= '0;
      r_div    <= '0;
`ifdef NCO_SWEEP_EN
      r_ftw_start <= '0;
      r_step      <= '0;
      r_limit     <= '0;
`endif
    end else begin
`ifdef NCO_SWEEP_EN
      if (w_produce) r_ftw <= w_ftw_swept;
`endif
      if (bus.cfg_we) begin
        case (bus.cfg_addr)
          NCO_ADDR_FTW: begin
            r_ftw <= bus.cfg_wdata;
`ifdef NCO_SWEEP_EN
            r_ftw_start <= bus.cfg_wdata;
`endif
          end
          NCO_ADDR_OFFSET: r_offset <= bus.cfg_wdata;
          NCO_ADDR_DIV:    r_div    <= bus.cfg_wdata[DIV_W-1:0];
`ifdef NCO_SWEEP_EN
          NCO_ADDR_STEP:   r_step   <= bus.cfg_wdata;
          NCO_ADDR_LIMIT:  r_limit  <= bus.cfg_wdata;
`endif
          default: ;
        endcase
      end
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= NCO_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic. On disable we look at the slot as it will be next
  // cycle, so a sample produced by a coincident tick is still drained.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      NCO_IDLE: begin
        if (w_ctrl_wr && bus.cfg_wdata[NCO_CTRL_EN]) w_next_state = NCO_RUN;
      end
      NCO_RUN: begin
        if (w_ctrl_wr && !bus.cfg_wdata[NCO_CTRL_EN])
          w_next_state = w_valid_next ? NCO_DRAIN : NCO_IDLE;
      end
      NCO_DRAIN: begin
        if (w_accept) w_next_state = NCO_IDLE;
      end
      default: w_next_state = NCO_IDLE;
    endcase
  end

  // Accumulator, output register and status flags. Phase clear beats a
  // tick (the divider already masks it); a fresh overrun beats its clear so
  // an event in the clearing cycle is not lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc     <= '0;
      r_angle   <= '0;
      r_valid   <= 1'b0;
      r_running <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_phase_clr)    r_acc <= '0;
      else if (w_produce) r_acc <= r_acc + r_ftw;

      if (w_produce) r_angle <= r_acc + r_offset;

      r_valid   <= w_valid_next;
      r_running <= (w_next_state == NCO_RUN);

      if (w_drop)         r_overrun <= 1'b1;
      else if (w_ovr_clr) r_overrun <= 1'b0;
    end
  end

  assign bus.angle       = r_angle;
  assign bus.angle_valid = r_valid;
  assign bus.running     = r_running;
  assign bus.overrun     = r_overrun;

endmodule
